// File: rtl/timer_counter.sv
// Bus-mapped down-counting timer with one-shot and auto-reload modes.
// Register window (16 bytes at BASE):
//   +0x0 CTRL   : [0] EN, [2:1] MODE, [3] IM (upper bits read 0)
//   +0x4 PRESET : reload value, R/W
//   +0x8 COUNT  : running count, read-only
//   +0xC        : unmapped, reads 0, writes ignored
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCnt,
    StInt
  } state_e;

  localparam logic [1:0] ModeReload = 2'b01;

  state_e      state_q;
  logic        en_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        pend_q;

  logic        hit;
  logic [1:0]  offset;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en_clr;
  logic        pend_set;
  logic        pend_clr;

  // Byte-lane bits of addr and upper data bits of a CTRL write carry no meaning.
  logic        unused_bits;
  assign unused_bits = ^{addr[1:0], din[31:4]};

  // Address decode and write strobes for the writable registers.
  always_comb begin
    hit       = (addr[31:4] == BASE[31:4]);
    offset    = addr[3:2];
    wr_ctrl   = we && hit && (offset == 2'd0);
    wr_preset = we && hit && (offset == 2'd1);
  end

  // FSM-side events: one-shot EN auto-clear, PEND set on terminal count,
  // PEND clear on service write or on the auto-reload transition.
  always_comb begin
    en_clr   = (state_q == StInt) && (mode_q != ModeReload);
    pend_set = (state_q == StCnt) && en_q && (count_q <= 32'd1);
    pend_clr = wr_ctrl || wr_preset || ((state_q == StInt) && (mode_q == ModeReload));
  end

  // CTRL register: a bus write takes priority over the one-shot EN auto-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q   <= 1'b0;
      mode_q <= 2'b00;
      im_q   <= 1'b0;
    end else if (wr_ctrl) begin
      en_q   <= din[0];
      mode_q <= din[2:1];
      im_q   <= din[3];
    end else if (en_clr) begin
      en_q   <= 1'b0;
    end
  end

  // PRESET register: only sampled by the FSM in LOAD, so mid-count writes
  // affect the next period only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset_q <= 32'd0;
    end else if (wr_preset) begin
      preset_q <= din;
    end
  end

  // Counter FSM with registered COUNT and PEND; PEND set beats a same-edge clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= 32'd0;
      pend_q  <= 1'b0;
    end else begin
      if (pend_set) begin
        pend_q <= 1'b1;
      end else if (pend_clr) begin
        pend_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (en_q) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          count_q <= preset_q;
          state_q <= StCnt;
        end
        StCnt: begin
          if (!en_q) begin
            state_q <= StIdle;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            // PRESET of 0 lands here too, so it behaves like PRESET of 1.
            count_q <= 32'd0;
            state_q <= StInt;
          end
        end
        StInt: begin
          if (mode_q == ModeReload) begin
            state_q <= StLoad;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Combinational read mux; misses and the unmapped slot read as 0.
  always_comb begin
    dout = 32'd0;
    if (hit) begin
      case (offset)
        2'd0:    dout = {28'd0, im_q, mode_q, en_q};
        2'd1:    dout = preset_q;
        2'd2:    dout = count_q;
        default: dout = 32'd0;
      endcase
    end
  end

  assign irq = pend_q & im_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: inputs change just after the falling
// edge, outputs are sampled in the low phase, away from the rising edge.
module tb_timer_counter;

  localparam logic [31:0] Base   = 32'h0000_7F00;
  localparam logic [31:0] ACtrl  = Base + 32'h0;
  localparam logic [31:0] APre   = Base + 32'h4;
  localparam logic [31:0] ACnt   = Base + 32'h8;
  localparam logic [31:0] AUnmap = Base + 32'hC;
  localparam logic [31:0] AMiss  = 32'h0000_7F10;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks;
  int passed;

  timer_counter #(.BASE(Base)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reads are combinational: settle 1 time unit then compare.
  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  // Write occupies one rising edge; returns at the following falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
    din  = 32'd0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [31:0] seq_cnt [5];
    logic        seq_irq [5];
    seq_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    seq_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    checks = 0;
    passed = 0;
    reset  = 1'b0;
    addr   = 32'd0;
    we     = 1'b0;
    din    = 32'd0;

    // Reset state
    step(2);
    check_reg("rst_ctrl", ACtrl, 32'd0);
    check_reg("rst_preset", APre, 32'd0);
    check_reg("rst_count", ACnt, 32'd0);
    check_irq("rst_irq", 1'b0);
    reset = 1'b1;
    step(2);

    // One-shot, PRESET=5, EN at edge T -> INT in cycle T+7, irq sticks.
    bus_write(APre, 32'd5);
    bus_write(ACtrl, 32'h9);                 // now in cycle T
    check_irq("os_irq_T", 1'b0);
    step(2);                                 // T+2
    check_reg("os_count_T2", ACnt, 32'd5);
    step(4);                                 // T+6
    check_reg("os_count_T6", ACnt, 32'd1);
    check_irq("os_irq_T6", 1'b0);
    step(1);                                 // T+7
    check_irq("os_irq_T7", 1'b1);
    check_reg("os_count_T7", ACnt, 32'd0);
    step(1);                                 // T+8
    check_irq("os_irq_hold", 1'b1);
    check_reg("os_ctrl_en_clr", ACtrl, 32'h8);
    step(3);
    check_irq("os_irq_hold2", 1'b1);
    bus_write(ACtrl, 32'h8);                 // keep IM, service PEND
    check_irq("os_irq_serviced", 1'b0);

    // Auto-reload, PRESET=3: period 5, COUNT 3,2,1,0,0, irq on the 0 in INT.
    bus_write(APre, 32'd3);
    bus_write(ACtrl, 32'hB);                 // cycle T
    step(2);                                 // T+2
    for (int i = 0; i < 10; i++) begin
      check_reg($sformatf("ar_count_%0d", i), ACnt, seq_cnt[i % 5]);
      check_irq($sformatf("ar_irq_%0d", i), seq_irq[i % 5]);
      step(1);
    end
    // Cycle T+12 reads 3; disabling lets one more decrement land, then holds.
    bus_write(ACtrl, 32'h0);
    step(2);
    check_reg("ar_count_held", ACnt, 32'd2);
    step(2);
    check_reg("ar_count_held2", ACnt, 32'd2);

    // IM=0 one-shot, PRESET=2: no irq, EN auto-clears; CTRL write clears PEND.
    bus_write(APre, 32'd2);
    bus_write(ACtrl, 32'h1);                 // cycle T
    step(4);                                 // T+4: INT
    check_irq("nim_irq_int", 1'b0);
    check_reg("nim_count_int", ACnt, 32'd0);
    step(1);
    check_reg("nim_ctrl_en0", ACtrl, 32'h0);
    bus_write(ACtrl, 32'h8);
    check_irq("nim_irq_after_im", 1'b0);

    // Auto-reload PRESET=10; rewrite PRESET=2 at COUNT=6.
    bus_write(APre, 32'd10);
    bus_write(ACtrl, 32'hB);                 // cycle T
    step(6);                                 // T+6
    check_reg("pw_count_6", ACnt, 32'd6);
    bus_write(APre, 32'd2);                  // cycle T+7
    check_reg("pw_count_5", ACnt, 32'd5);
    step(4);                                 // T+11
    check_irq("pw_irq_T11", 1'b0);
    step(1);                                 // T+12
    check_irq("pw_irq_T12", 1'b1);
    step(2);                                 // T+14
    check_reg("pw_reload_2", ACnt, 32'd2);
    step(2);                                 // T+16
    check_irq("pw_irq_T16", 1'b1);

    // Async reset mid-count (PRESET=100 loaded at T+18).
    bus_write(APre, 32'd100);                // cycle T+17 (LOAD)
    step(3);                                 // T+20
    check_reg("rs_count_98", ACnt, 32'd98);
    reset = 1'b0;
    check_reg("rs_count_0", ACnt, 32'd0);
    check_reg("rs_ctrl_0", ACtrl, 32'd0);
    check_irq("rs_irq_0", 1'b0);
    reset = 1'b1;
    step(3);
    check_reg("rs_idle_count", ACnt, 32'd0);
    check_reg("rs_preset_0", APre, 32'd0);

    // Unmapped offset, non-matching window and COUNT writes are ignored.
    bus_write(APre, 32'd7);
    bus_write(ACtrl, 32'h8);
    bus_write(AUnmap, 32'hFFFF_FFFF);
    bus_write(AMiss, 32'hFFFF_FFFF);
    bus_write(ACnt, 32'h1234_5678);
    check_reg("map_ctrl", ACtrl, 32'h8);
    check_reg("map_preset", APre, 32'd7);
    check_reg("map_count", ACnt, 32'd0);
    step(1);
    check_reg("map_unmap_rd", AUnmap, 32'd0);
    check_reg("map_miss_rd", AMiss, 32'd0);

    // Same-edge priority: bus CTRL write beats EN auto-clear; PEND set beats clear.
    bus_write(APre, 32'd1);
    bus_write(ACtrl, 32'h9);                 // cycle T
    step(3);                                 // T+3: INT
    check_irq("pri_irq_int", 1'b1);
    bus_write(ACtrl, 32'h9);                 // T+4, collides with auto-clear
    check_reg("pri_ctrl_bus_wins", ACtrl, 32'h9);
    check_irq("pri_irq_cleared", 1'b0);
    step(2);                                 // T+6: CNT, COUNT=1
    check_reg("pri_count_1", ACnt, 32'd1);
    bus_write(APre, 32'd1);                  // T+7, collides with PEND set
    check_irq("pri_pend_wins", 1'b1);
    bus_write(ACtrl, 32'h0);
    check_irq("pri_final_clear", 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_7F00, the word-aligned base address of the 16-byte register window.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port addr, input, 32 bits: bus byte address; addr[1:0] ignored.
REQ-005 SHALL have port we, input, 1 bit: bus write strobe, sampled at the rising clk edge.
REQ-006 SHALL have port din, input, 32 bits: bus write data.
REQ-007 SHALL have port dout, output, 32 bits: combinational read data for addr.
REQ-008 SHALL have port irq, output, 1 bit: interrupt request, wired to one CP0 HWInt line.

Function
REQ-009 SHALL decode a hit when addr[31:4]==BASE[31:4]; offset = addr[3:2].
REQ-010 SHALL map offset 0 to CTRL, 1 to PRESET and 2 to COUNT; offset 3 is unmapped.
REQ-011 CTRL fields SHALL be [0] EN, [2:1] MODE, [3] IM; bits [31:4] SHALL read 0.
REQ-012 PRESET SHALL be 32-bit R/W; COUNT SHALL be 32-bit read-only, and writes to COUNT or unmapped offsets SHALL be ignored.
REQ-013 dout SHALL equal the addressed register on a hit, otherwise 0, with no added latency.
REQ-014 SHALL implement the FSM states IDLE, LOAD, CNT and INT, registered, with no other states reachable.
REQ-015 IDLE SHALL move to LOAD the cycle after EN=1 is sampled, otherwise stay in IDLE.
REQ-016 LOAD SHALL set COUNT<=PRESET and move to CNT.
REQ-017 In CNT, if EN=0 the FSM SHALL move to IDLE with COUNT held.
REQ-018 In CNT, if EN=1 and COUNT>1, the FSM SHALL set COUNT<=COUNT-1 and stay in CNT.
REQ-019 In CNT, if EN=1 and COUNT<=1, the FSM SHALL set COUNT<=0 and PEND<=1 and move to INT.
REQ-020 INT with MODE==01 SHALL move to LOAD (auto-reload), with PEND cleared on that transition.
REQ-021 INT with any other MODE SHALL be one-shot: clear EN and move to IDLE, with PEND held.
REQ-022 irq SHALL equal PEND & IM, driven from registers only.
REQ-023 In one-shot mode, PEND SHALL clear only on a bus write hitting CTRL or PRESET, so irq holds until serviced.
REQ-024 In auto-reload mode, irq SHALL be high for exactly one cycle per period when IM=1.
REQ-025 Latency: with EN written at edge T and PRESET=N>=1, LOAD SHALL occupy cycle T+1, COUNT SHALL equal N in cycle T+2, and state INT with irq high SHALL occur in cycle T+2+N.
REQ-026 PRESET=0 SHALL behave as PRESET=1 (INT in cycle T+2+1).
REQ-027 A PRESET write during CNT SHALL not alter the running COUNT and SHALL take effect at the next LOAD.
REQ-028 If a bus CTRL write and the INT-state EN auto-clear occur on the same edge, the bus write SHALL win.
REQ-029 If a bus CTRL/PRESET write and PEND set (CNT->INT) occur on the same edge, PEND set SHALL win.
REQ-030 COUNT SHALL never wrap below 0, and no arithmetic SHALL exceed 32 bits.

Reset
REQ-031 While reset=0, asynchronously: state=IDLE, CTRL=0, PRESET=0, COUNT=0, PEND=0, irq=0, dout reflects the zeroed registers.
REQ-032 Reset asserted mid-count SHALL abort immediately; after release the block SHALL stay in IDLE until EN is written.

Verification
REQ-033 Scenario: write PRESET=5, then CTRL=0x9 (EN, IM, mode 0) at edge T -> irq rises in cycle T+7 and stays high; CTRL reads 0x8; a CTRL write of 0 clears irq the next cycle.
REQ-034 Scenario: PRESET=3, CTRL=0xB (auto-reload) -> irq one-cycle pulses with period 5 cycles (LOAD + 3 CNT + INT); COUNT reads 3,2,1,0 repeatedly.
REQ-035 Scenario: IM=0, mode 0, PRESET=2 -> irq stays 0; PEND is visible via irq within 1 cycle of a CTRL write setting IM=1 without clearing EN... Pending: a write to CTRL clears PEND, so the bench checks irq stays 0 and EN reads 0 after INT.
REQ-036 Scenario: PRESET=10 running; at COUNT=6, write PRESET=2 -> current period ends after the original 10; the next reload counts 2.
REQ-037 Scenario: PRESET=100 running; pull reset low between edges -> COUNT, CTRL and irq read 0 before the next clk edge.
REQ-038 Scenario: write to BASE+0xC and to a non-matching address -> no register changes and dout=0.
